// File: rtl/fifo_write_ctrl.sv
// Write-side controller for the cell-based FIFO.
// Rotates a one-hot write pointer around the cell ring and accepts producer
// words on a req/ack handshake. Each accepted word becomes a one-cycle
// write-enable pulse to the target cell. The block also reports full,
// almost_full and a sticky overflow flag.
module fifo_write_ctrl #(
  parameter int unsigned N_CELLS   = 16,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned AF_MARGIN = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                put_req,
  input  logic [DATA_W-1:0]   put_data,
  output logic                put_ack,
  input  logic [N_CELLS-1:0]  f_i,
  output logic [N_CELLS-1:0]  we_o,
  output logic [DATA_W-1:0]   data_o,
  output logic                full,
  output logic                almost_full,
  output logic                overflow,
  input  logic                clr_ovf
);

  localparam int unsigned OccW = $clog2(N_CELLS + 1);

  // StSettle covers the edge between seeing empty cells and entering RUN.
  typedef enum logic [1:0] {
    StInit,
    StSettle,
    StRun
  } state_e;

  state_e             state_q;
  logic [N_CELLS-1:0] wptr_q;
  logic [OccW-1:0]    occ;
  logic               run;

  assign run = (state_q == StRun);

  // Full follows the live cell flags so a cell freed this cycle can be refilled at once.
  always_comb begin
    full    = ~run | (|(f_i & wptr_q));
    put_ack = run & put_req & ~full;
  end

  // Occupancy includes the write in flight that the cells have not yet flagged.
  always_comb begin
    occ = '0;
    for (int unsigned i = 0; i < N_CELLS; i++) begin
      occ = occ + OccW'(f_i[i]);
    end
    occ = occ + OccW'(we_o != '0);
  end

  // Control FSM together with the pointer, write pulse, data and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StInit;
      wptr_q      <= N_CELLS'(1);
      we_o        <= '0;
      data_o      <= '0;
      almost_full <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      unique case (state_q)
        StInit:   if (f_i == '0) state_q <= StSettle;
        StSettle: state_q <= StRun;
        StRun:    state_q <= StRun;
        default:  state_q <= StInit;
      endcase

      if (put_ack) begin
        we_o   <= wptr_q;
        data_o <= put_data;
        wptr_q <= {wptr_q[N_CELLS-2:0], wptr_q[N_CELLS-1]};
      end else begin
        we_o <= '0;
      end

      almost_full <= (occ >= OccW'(N_CELLS - AF_MARGIN));

      // A new overflow event takes priority over a clear in the same cycle.
      if (run && put_req && full) begin
        overflow <= 1'b1;
      end else if (clr_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_write_ctrl.sv
// Bench for fifo_write_ctrl: a ring-level reference model is checked against the DUT on every
// cycle, and directed scenarios add hand-computed literal expectations.
module tb_fifo_write_ctrl;

  localparam int N   = 16;
  localparam int DW  = 8;
  localparam int AFM = 2;

  logic          clk      = 1'b0;
  logic          rst_n    = 1'b1;
  logic          put_req  = 1'b0;
  logic [DW-1:0] put_data = '0;
  logic          put_ack;
  logic [N-1:0]  f_i      = '0;
  logic [N-1:0]  we_o;
  logic [DW-1:0] data_o;
  logic          full;
  logic          almost_full;
  logic          overflow;
  logic          clr_ovf  = 1'b0;

  int vectors     = 0;
  int miscompares = 0;

  // Cell emulation: a written cell raises its flag two edges after the accept.
  logic         cells_on = 1'b0;
  logic [N-1:0] pend     = '0;

  fifo_write_ctrl #(
    .N_CELLS  (N),
    .DATA_W   (DW),
    .AF_MARGIN(AFM)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .put_req    (put_req),
    .put_data   (put_data),
    .put_ack    (put_ack),
    .f_i        (f_i),
    .we_o       (we_o),
    .data_o     (data_o),
    .full       (full),
    .almost_full(almost_full),
    .overflow   (overflow),
    .clr_ovf    (clr_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: pointer as a ring index, start-up as "seen empty" then "running".
  int            m_ptr;
  logic [N-1:0]  m_we;
  logic [DW-1:0] m_data;
  logic          m_af, m_ovf, m_zero, m_run;
  logic          m_full, m_ack;

  assign m_full = !m_run || f_i[m_ptr];
  assign m_ack  = m_run && put_req && !m_full;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ptr  <= 0;
      m_we   <= '0;
      m_data <= '0;
      m_af   <= 1'b0;
      m_ovf  <= 1'b0;
      m_zero <= 1'b0;
      m_run  <= 1'b0;
    end else begin
      m_we <= m_ack ? (N'(1) << m_ptr) : '0;
      if (m_ack) begin
        m_data <= put_data;
        m_ptr  <= (m_ptr + 1) % N;
      end
      m_af <= ($countones(f_i) + ((m_we != 0) ? 1 : 0)) >= (N - AFM);
      if (m_run && put_req && m_full) m_ovf <= 1'b1;
      else if (clr_ovf)               m_ovf <= 1'b0;
      if (!m_run) begin
        if (m_zero)        m_run  <= 1'b1;
        else if (f_i == 0) m_zero <= 1'b1;
      end
    end
  end

  // Every-cycle compare on the falling edge, away from input changes and the active edge.
  always @(negedge clk) begin
    chk("put_ack", 32'(put_ack), 32'(m_ack));
    chk("full", 32'(full), 32'(m_full));
    chk("we_o", 32'(we_o), 32'(m_we));
    chk("data_o", 32'(data_o), 32'(m_data));
    chk("almost_full", 32'(almost_full), 32'(m_af));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("wptr_onehot", 32'($onehot(dut.wptr_q)), 32'd1);
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (cells_on) begin
      f_i  = f_i | pend;
      pend = we_o;
    end
  endtask

  initial begin
    // Reset with empty cells: full through the first edge, RUN after the second.
    #2 rst_n = 1'b0;
    put_req = 1'b1;
    #1;
    chk("rst_full", 32'(full), 32'd1);
    chk("rst_ack", 32'(put_ack), 32'd0);
    chk("rst_wptr", 32'(dut.wptr_q), 32'h0001);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    chk("edge1_full", 32'(full), 32'd1);
    chk("edge1_ack", 32'(put_ack), 32'd0);
    put_req = 1'b0;
    step();
    chk("edge2_full", 32'(full), 32'd0);
    chk("edge2_ovf", 32'(overflow), 32'd0);

    // Fill the whole ring with back-to-back accepts.
    cells_on = 1'b1;
    for (int i = 0; i < N; i++) begin
      put_req  = 1'b1;
      put_data = DW'(i);
      step();
      chk("fill_we", 32'(we_o), 32'(N'(1) << i));
      chk("fill_data", 32'(data_o), i);
    end
    put_req = 1'b0;
    step();
    chk("fill_we_end", 32'(we_o), 32'd0);
    step();
    step();
    chk("ring_full", 32'(full), 32'd1);
    chk("ring_af", 32'(almost_full), 32'd1);
    chk("wrap_wptr", 32'(dut.wptr_q), 32'h0001);

    // Requests against a full ring are refused and set the sticky overflow.
    put_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("full_ack", 32'(put_ack), 32'd0);
      step();
      chk("full_we", 32'(we_o), 32'd0);
      chk("full_ovf", 32'(overflow), 32'd1);
    end
    put_req = 1'b0;
    step();
    chk("ovf_hold", 32'(overflow), 32'd1);
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    chk("ovf_clr", 32'(overflow), 32'd0);
    put_req = 1'b1;
    clr_ovf = 1'b1;
    step();
    chk("ovf_set_wins", 32'(overflow), 32'd1);
    put_req = 1'b0;
    step();
    clr_ovf = 1'b0;
    chk("ovf_clr2", 32'(overflow), 32'd0);

    // almost_full at 14 occupied cells, clear at 13.
    cells_on = 1'b0;
    pend     = '0;
    f_i      = 16'h3FFF;
    step();
    step();
    chk("af_14", 32'(almost_full), 32'd1);
    f_i = 16'h1FFF;
    step();
    chk("af_13", 32'(almost_full), 32'd0);

    // Move the pointer to cell 2, then free that cell in the same cycle as a request.
    f_i      = '0;
    cells_on = 1'b1;
    put_req  = 1'b1;
    put_data = 8'h11;
    step();
    put_data = 8'h22;
    step();
    put_req  = 1'b0;
    cells_on = 1'b0;
    pend     = '0;
    f_i      = 16'h0007;
    step();
    chk("ptr2_full", 32'(full), 32'd1);
    chk("ptr2_wptr", 32'(dut.wptr_q), 32'h0004);
    f_i      = 16'h0003;
    put_req  = 1'b1;
    put_data = 8'hA5;
    #1;
    chk("free_ack", 32'(put_ack), 32'd1);
    step();
    put_req = 1'b0;
    chk("free_we", 32'(we_o), 32'h0004);
    chk("free_data", 32'(data_o), 32'h00A5);

    // Asynchronous reset while a write pulse is out; cells still hold data.
    f_i = 16'h0010;
    #1 rst_n = 1'b0;
    #1;
    chk("arst_we", 32'(we_o), 32'd0);
    chk("arst_wptr", 32'(dut.wptr_q), 32'h0001);
    chk("arst_ovf", 32'(overflow), 32'd0);
    chk("arst_full", 32'(full), 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    step();
    chk("init_hold", 32'(full), 32'd1);
    f_i = '0;
    step();
    chk("init_settle", 32'(full), 32'd1);
    step();
    chk("init_run", 32'(full), 32'd0);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Hard stop in case the scenario sequence ever stalls.
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fifo_write_ctrl.md
Name: fifo_write_ctrl

Overview:
- Write-side controller for the cell-based FIFO; the counterpart of the read-side empty logic.
- Owns a one-hot write pointer that rotates around the N_CELLS ring and accepts producer words on a req/ack handshake.
- Issues a one-cycle write-enable pulse to the target cell and generates full, almost_full and sticky overflow status from the per-cell full flags.

Parameters:
- N_CELLS, 16, number of FIFO cells in the ring; legal range 2..64.
- DATA_W, 8, width of the data word.
- AF_MARGIN, 2, almost_full asserts when occupancy >= N_CELLS-AF_MARGIN; legal range 1..N_CELLS-1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- put_req  input  1  producer has a word to write.
- put_data  input  DATA_W  producer word; valid while put_req is high.
- put_ack  output  1  word accepted this cycle (combinational).
- f_i  input  N_CELLS  per-cell full flag; 1 means the cell holds data. Driven by the cells.
- we_o  output  N_CELLS  one-hot write-enable pulse to the cells (registered).
- data_o  output  DATA_W  write data to the cells (registered); valid when we_o is non-zero.
- full  output  1  cell at the write pointer is occupied, or state is INIT.
- almost_full  output  1  registered occupancy threshold flag.
- overflow  output  1  sticky: put_req was seen while full.
- clr_ovf  input  1  synchronous clear of overflow.

Behaviour:
Reset (rst_n low, asynchronous):
- state=INIT, wptr=one-hot bit 0, we_o=0, data_o=0, almost_full=0, overflow=0.
- full=1, because state is INIT.

States:
- INIT: remain until f_i is all zeros on a clock edge, then go to RUN on the next edge. No accepts are made in INIT, so put_ack=0 and full=1.
- RUN: normal operation. There is no exit except reset.

Full and handshake:
- In RUN, full = |(f_i & wptr), i.e. the cell at the write pointer is occupied.
- put_ack = (state==RUN) & put_req & ~full.

Accept at edge t (put_ack high):
- we_o <= wptr; data_o <= put_data; wptr rotates left by one, with bit N_CELLS-1 wrapping to bit 0.
- Latency: exactly one cycle. we_o is high for cycle t+1 only, then returns to 0 unless another accept occurs.
- Back-to-back accepts are allowed every cycle. The cell just written is never the new pointer target because N_CELLS >= 2. The cell raises its f_i bit at t+2.

Non-accept cycles:
- we_o <= 0; data_o holds its value; wptr holds.

Occupancy and almost_full:
- occ = popcount(f_i) + (we_o != 0). This counts the write in flight that is not yet reflected in f_i.
- almost_full <= (occ >= N_CELLS-AF_MARGIN), registered once per cycle.
- The occ width is ceil(log2(N_CELLS+1)) bits, and occ cannot exceed N_CELLS.

Overflow:
- Set when state==RUN & put_req & full.
- A set in the same cycle as clr_ovf wins.
- Otherwise cleared by clr_ovf; held otherwise.
- A rejected request is not consumed: the producer must hold put_req and put_data until put_ack.

Boundary conditions:
- Reader frees the pointer cell in the same cycle put_req arrives: full follows live f_i, so the accept happens that cycle.
- Ring completely full: full=1 and put_ack=0, independent of put_req.
- wptr must be exactly one-hot at all times. A non-one-hot value is a design error, covered by a bench assertion.
- Reset mid-operation: an asynchronous reset kills any we_o pulse in flight immediately. The block re-enters INIT and waits for the cells to clear.

Test Plan:
- Reset with f_i=0x0000 -> full=1 during reset and for the first edge; RUN on the 2nd edge; put_ack=0 until then.
- N_CELLS=16, RUN, put_req held with data 0x00..0x0F, cells set f_i one cycle after we_o -> we_o=0x0001,0x0002,…,0x8000 on consecutive cycles, with data_o matching; wptr wraps back to 0x0001.
- f_i=0xFFFF, put_req=1 for 3 cycles -> put_ack=0, we_o=0, overflow=1 and stays 1; clr_ovf pulse with put_req=0 -> overflow=0.
- wptr=0x0004, f_i bit2 falls in the same cycle put_req=1 with data 0xA5 -> put_ack=1 that cycle; we_o=0x0004 and data_o=0xA5 next cycle.
- AF_MARGIN=2, fill to 13 cells then write the 14th -> almost_full rises the cycle after the 14th we_o pulse (occ=14) and falls when occupancy drops to 13.
- rst_n low on the cycle after an accept -> we_o forced to 0 immediately, wptr=0x0001, overflow=0; with f_i nonzero the block stays in INIT (full=1) until f_i reaches 0.
